// File: rtl/complex_mul_seq_pkg.sv
// ---------------------------------------------------------------------------
// cmul_pkg
// Shared definitions for the sequential complex multiplier:
//   - DW / PW / RW   operand, product and accumulator widths
//   - TMP_W and the field offsets of the packed {re, im} result word
//   - state_t        FSM states (IDLE, P0..P3, OUT)
//   - sext_prod()    sign-extends one PW-bit product to RW bits
// ---------------------------------------------------------------------------
package cmul_pkg;

    localparam int DW    = 16;        // operand component width
    localparam int PW    = 2 * DW;    // single partial product width
    localparam int RW    = 2 * DW + 1; // accumulator / result component width
    localparam int TMP_W = 2 * RW;    // packed {re, im} width

    localparam int RE_MSB = 2 * RW - 1;
    localparam int RE_LSB = RW;
    localparam int IM_MSB = RW - 1;
    localparam int IM_LSB = 0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P1   = 3'd2,
        P2   = 3'd3,
        P3   = 3'd4,
        OUT  = 3'd5
    } state_t;

    function automatic logic signed [RW-1:0] sext_prod(input logic signed [PW-1:0] p);
        return {p[PW-1], p};
    endfunction

endpackage

// File: rtl/complex_mul_seq_if.sv
// ---------------------------------------------------------------------------
// complex_mul_seq_if
// Operand/result handshake bundle of the sequential complex multiplier.
//   in_valid/in_ready   operand pair handshake, a = {a_re, a_im}, b = {b_re, b_im}
//   ctrl_in             accumulate-mode tag travelling with the operands
//   out_valid/out_ready result handshake, tmp = {re, im}, ctrl_out = tag
// Modports: slave = the multiplier, master = the producer/consumer around it.
// ---------------------------------------------------------------------------
interface complex_mul_seq_if;
    import cmul_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [2*DW-1:0]   a;
    logic [2*DW-1:0]   b;
    logic [1:0]        ctrl_in;
    logic              out_valid;
    logic              out_ready;
    logic [TMP_W-1:0]  tmp;
    logic [1:0]        ctrl_out;

    modport slave (
        input  in_valid, a, b, ctrl_in, out_ready,
        output in_ready, out_valid, tmp, ctrl_out
    );

    modport master (
        output in_valid, a, b, ctrl_in, out_ready,
        input  in_ready, out_valid, tmp, ctrl_out
    );

endinterface

// File: rtl/complex_mul_seq_mult.sv
// ---------------------------------------------------------------------------
// cmul_mult
// Combinational DW x DW signed multiplier shared by all four partial products.
//   x, y : signed DW-bit operands
//   p    : signed PW-bit exact product
// ---------------------------------------------------------------------------
module cmul_mult
    import cmul_pkg::*;
(
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] y,
    output logic signed [PW-1:0] p
);

    assign p = x * y;

endmodule

// File: rtl/complex_mul_seq.sv
// ---------------------------------------------------------------------------
// complex_mul_seq
// Sequential 16-bit complex multiplier: one operand pair per transaction,
// four partial products on a single shared multiplier (one per cycle), exact
// 33-bit real/imaginary results packed as {re, im} on tmp plus the ctrl tag.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : complex_mul_seq_if.slave (operand and result handshakes)
// All outputs are registers or registered state decodes.
// ---------------------------------------------------------------------------
module complex_mul_seq
    import cmul_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    complex_mul_seq_if.slave       bus
);

    state_t state, next_state;

    logic signed [DW-1:0] a_re, a_im, b_re, b_im;
    logic        [1:0]    ctrl_q;
    logic signed [RW-1:0] acc_re, acc_im;
    logic                 in_ready_q, out_valid_q;

    logic signed [DW-1:0] mul_x, mul_y;
    logic signed [PW-1:0] prod;
    logic signed [RW-1:0] prod_x;
    logic                 accept;

    assign accept = (state == IDLE) && bus.in_valid;
    assign prod_x = sext_prod(prod);

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values of the others.
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves next_state unassigned
        // and no latch is inferred.
        next_state = state;
        unique case (state)
            IDLE:    if (bus.in_valid) next_state = P0;
            P0:      next_state = P1;
            P1:      next_state = P2;
            P2:      next_state = P3;
            P3:      next_state = OUT;
            OUT:     if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand muxes for the shared multiplier, selected by compute state.
    always_comb begin
        mul_x = a_re;
        mul_y = b_re;
        unique case (state)
            P1:      begin mul_x = a_im; mul_y = b_im; end
            P2:      begin mul_x = a_re; mul_y = b_im; end
            P3:      begin mul_x = a_im; mul_y = b_re; end
            default: begin mul_x = a_re; mul_y = b_re; end
        endcase
    end

    cmul_mult u_mult (
        .x (mul_x),
        .y (mul_y),
        .p (prod)
    );

    // -----------------------------------------------------------------------
    // Datapath and registered handshake outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the operand and accumulator registers are plain flops, not
            // a memory array, so clearing them on reset is cheap and required.
            a_re        <= '0;
            a_im        <= '0;
            b_re        <= '0;
            b_im        <= '0;
            ctrl_q      <= '0;
            acc_re      <= '0;
            acc_im      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                a_re   <= bus.a[PW-1:DW];
                a_im   <= bus.a[DW-1:0];
                b_re   <= bus.b[PW-1:DW];
                b_im   <= bus.b[DW-1:0];
                ctrl_q <= bus.ctrl_in;
            end

            unique case (state)
                P0:      acc_re <= prod_x;
                P1:      acc_re <= acc_re - prod_x;
                P2:      acc_im <= prod_x;
                P3:      acc_im <= acc_im + prod_x;
                default: ;
            endcase

            // Registered decodes of the state being entered, so neither
            // in_valid nor out_ready reaches an output combinationally.
            in_ready_q  <= (next_state == IDLE);
            out_valid_q <= (next_state == OUT);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.tmp       = {acc_re, acc_im};
    assign bus.ctrl_out  = ctrl_q;

endmodule

// File: tb/tb_complex_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_complex_mul_seq
// Directed-vector bench for complex_mul_seq with a scoreboard: expected
// results are queued at operand acceptance and a monitor compares every
// transferred result in order.
// ---------------------------------------------------------------------------
module tb_complex_mul_seq;
    import cmul_pkg::*;

    typedef struct {
        logic [RW-1:0] re;
        logic [RW-1:0] im;
        logic [1:0]    ctrl;
    } exp_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   results  = 0;
    exp_t sb[$];
    int   out_cyc[$];

    complex_mul_seq_if bus ();

    complex_mul_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: a transfer happens at the next posedge when out_valid && out_ready.
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            out_cyc.push_back(cyc);
            results++;
            if (sb.size() == 0) begin
                check("unexpected_result", 66'(bus.out_valid), 66'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_re",   66'(bus.tmp[RE_MSB:RE_LSB]), 66'(e.re));
                check("result_im",   66'(bus.tmp[IM_MSB:IM_LSB]), 66'(e.im));
                check("result_ctrl", 66'(bus.ctrl_out),            66'(e.ctrl));
            end
        end
    end

    // All tasks are entered and left #1 after a posedge.
    task automatic wait_ready();
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.in_ready !== 1'b1) check("timeout_in_ready", 66'(0), 66'(1));
    endtask

    task automatic wait_out_valid();
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.out_valid !== 1'b1) check("timeout_out_valid", 66'(0), 66'(1));
    endtask

    // Issue one operand pair; returns #1 after the accepting edge.
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic [1:0] c,
                        input logic [RW-1:0] ere, input logic [RW-1:0] eim, input bit push);
        exp_t e;
        wait_ready();
        bus.a        = av;
        bus.b        = bv;
        bus.ctrl_in  = c;
        bus.in_valid = 1'b1;
        if (push) begin
            e.re = ere; e.im = eim; e.ctrl = c;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.ctrl_in   = 2'b00;
        bus.out_ready = 1'b1;
        rst           = 1'b1;

        // Reset state (rst still high after the edge).
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_in_ready",  66'(bus.in_ready),  66'(0));
        check("rst_out_valid", 66'(bus.out_valid), 66'(0));
        check("rst_tmp",       66'(bus.tmp),       66'(0));
        check("rst_ctrl_out",  66'(bus.ctrl_out),  66'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", 66'(bus.in_ready), 66'(1));

        // (3+4j)x(5-2j) = 23+14j, with latency checks.
        send({16'sd3, 16'sd4}, {16'sd5, -16'sd2}, 2'b01, 33'sd23, 33'sd14, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
            check("lat_out_valid_low", 66'(bus.out_valid), 66'(0));
        end
        @(posedge clk); #1;
        check("lat_out_valid_k4", 66'(bus.out_valid), 66'(1));
        @(posedge clk); #1;
        check("lat_out_valid_k5", 66'(bus.out_valid), 66'(0));
        check("lat_in_ready_k5",  66'(bus.in_ready),  66'(1));

        // Corner: (-32768-32768j)^2 = 0 + 2^31 j.
        send({-16'sd32768, -16'sd32768}, {-16'sd32768, -16'sd32768}, 2'b10,
             33'h0_0000_0000, 33'h0_8000_0000, 1'b1);
        // Corner: (-32768+32767j)x(-32768-32768j).
        send({-16'sd32768, 16'sd32767}, {-16'sd32768, -16'sd32768}, 2'b11,
             33'h0_7FFF_8000, 33'h0_0000_8000, 1'b1);

        // Backpressure: (5+6j)x(7+8j) = -13+82j held with out_ready low.
        wait_ready();
        bus.out_ready = 1'b0;
        send({16'sd5, 16'sd6}, {16'sd7, 16'sd8}, 2'b11, -33'sd13, 33'sd82, 1'b1);
        wait_out_valid();
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'($urandom);
            bus.a        = $urandom;
            bus.b        = $urandom;
            bus.ctrl_in  = 2'($urandom);
            @(posedge clk); #1;
            check("bp_tmp",       66'(bus.tmp),       {-33'sd13, 33'sd82});
            check("bp_ctrl_out",  66'(bus.ctrl_out),  66'(2'b11));
            check("bp_in_ready",  66'(bus.in_ready),  66'(0));
            check("bp_out_valid", 66'(bus.out_valid), 66'(1));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        // (-7+2j)x(3-4j) = -13+34j
        send({-16'sd7, 16'sd2}, {16'sd3, -16'sd4}, 2'b00, -33'sd13, 33'sd34, 1'b1);

        // Reset while in P2 drops the operation.
        send({16'sd9, 16'sd9}, {16'sd9, 16'sd9}, 2'b01, '0, '0, 1'b0);
        @(posedge clk); #1;             // P1
        @(posedge clk); #1;             // P2
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("p2rst_out_valid", 66'(bus.out_valid), 66'(0));
        check("p2rst_tmp",       66'(bus.tmp),       66'(0));
        check("p2rst_ctrl_out",  66'(bus.ctrl_out),  66'(0));
        check("p2rst_in_ready",  66'(bus.in_ready),  66'(0));
        @(posedge clk); #1;
        check("p2rst_in_ready_after", 66'(bus.in_ready), 66'(1));
        repeat (6) @(posedge clk);
        #1;
        check("p2rst_no_output", 66'(bus.out_valid), 66'(0));
        // (1+1j)x(1-1j) = 2+0j
        send({16'sd1, 16'sd1}, {16'sd1, -16'sd1}, 2'b10, 33'sd2, 33'sd0, 1'b1);

        // Back-to-back with out_ready always high.
        send({16'sd2, 16'sd0}, {16'sd0, 16'sd3}, 2'b01, 33'sd0, 33'sd6, 1'b1);
        send({-16'sd1, -16'sd1}, {-16'sd1, 16'sd1}, 2'b10, 33'sd2, 33'sd0, 1'b1);

        // Drain the scoreboard.
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("sb_drain",      66'(sb.size()), 66'(0));
        check("result_count",  66'(results),   66'(8));
        if (out_cyc.size() >= 2)
            check("b2b_spacing", 66'(out_cyc[out_cyc.size()-1] - out_cyc[out_cyc.size()-2]), 66'(6));
        else
            check("b2b_results", 66'(out_cyc.size()), 66'(2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/complex_mul_seq.md
# complex_mul_seq

Sequential 16-bit complex multiplier that feeds the conditional complex multiply-accumulate/subtract stage. It accepts one complex operand pair per transaction and computes the four partial products on a single shared signed multiplier, one product per cycle. It emits the exact 33-bit real and imaginary products packed as `{re, im}` on `tmp`, together with the transaction's `ctrl` tag, which is exactly the word layout the accumulator consumes.

## Interface
- `DW`, 16: operand component width, in two's complement.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: operand pair valid.
- `in_ready`, output, 1: block can accept an operand pair.
- `a`, input, 2*DW: `{a_re, a_im}`, both signed.
- `b`, input, 2*DW: `{b_re, b_im}`, both signed.
- `ctrl_in`, input, 2: accumulate-mode tag, carried unchanged to the output.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: downstream accepts the result.
- `tmp`, output, 4*DW+2: `{re[2*DW:0], im[2*DW:0]}`, signed.
- `ctrl_out`, output, 2: tag captured with the operands.

## Operation
- FSM states: IDLE, P0, P1, P2, P3, OUT.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, register `a`, `b` and `ctrl_in`, then go to P0.
- P0: `acc_re` = sext(a_re*b_re).
- P1: `acc_re` = `acc_re` − sext(a_im*b_im).
- P2: `acc_im` = sext(a_re*b_im).
- P3: `acc_im` = `acc_im` + sext(a_im*b_re). Go to OUT.
- OUT:
  - `out_valid`=1.
  - `tmp`, `ctrl_out`, `acc_re` and `acc_im` are held stable while `out_ready`=0.
  - On `out_ready`, go to IDLE.
- Arithmetic:
  - Each product is a 2*DW-bit signed value, sign-extended to 2*DW+1 bits.
  - Both accumulators are 2*DW+1 bits wide. The result is exact for every input, so no saturation and no overflow check are needed.
- `ctrl_in`=00 or 11 is still computed and tagged. Clearing on those codes is the consumer's job.
- `in_valid` is ignored outside IDLE. Operand inputs are sampled only on the accepting edge.
- `tmp` shows the accumulator registers at all times. It is defined only while `out_valid`=1.
- Reset (`rst`=1 at a clock edge):
  - State goes to IDLE.
  - `in_ready`=0 during reset, then 1 afterwards.
  - `out_valid`, `tmp`, `ctrl_out`, the accumulators and the operand registers all clear to 0.
  - Reset wins over any simultaneous handshake. An in-flight operation is dropped with no output.

## Timing
- Accept at edge k (IDLE, `in_valid`=1). States follow:
  - P0 after edge k.
  - P1 after edge k+1.
  - P2 after edge k+2.
  - P3 after edge k+3.
  - `out_valid`=1 after edge k+4.
- Result transfer happens at the first edge with `out_valid`&&`out_ready`. IDLE follows after that edge.
- Minimum initiation interval is 6 cycles: accept, 4 compute cycles, output.
- No combinational path from `out_ready` or `in_valid` to any output. Every output is a registered state decode or a register.

## Structure
- Package `cmul_pkg`:
  - state enum (IDLE, P0–P3, OUT);
  - `DW` default;
  - localparams PW = 2*DW and RW = 2*DW+1;
  - the tmp field-offset constants (re at [2*RW-1:RW], im at [RW-1:0]).
- One sub-module, `cmul_mult`: a combinational DW×DW signed multiplier.
  - Operand muxes select its inputs by state: P0 a_re/b_re, P1 a_im/b_im, P2 a_re/b_im, P3 a_im/b_re.

## Test plan
- (3+4j)×(5−2j), ctrl 01, accepted at edge k, `out_ready`=1:
  - `out_valid` rises after edge k+4.
  - re=23, im=14, `ctrl_out`=01.
  - `out_valid` low and `in_ready` high after edge k+5.
- (−32768−32768j)×(−32768−32768j):
  - re=0, im=33'h0_8000_0000 (+2^31, exact).
- (−32768+32767j)×(−32768−32768j):
  - re=33'h0_7FFF_8000, im=33'h0_0000_8000.
- Backpressure: hold `out_ready`=0 for 10 cycles in OUT while toggling `in_valid` and operands.
  - `tmp` and `ctrl_out` stay constant.
  - `in_ready`=0 throughout, and no second operation starts.
  - Release `out_ready`, then accept the next pair; its result is correct.
- Assert `rst` for one edge while in P2:
  - State returns to IDLE.
  - `out_valid`=0, `tmp`=0, `ctrl_out`=0, and no result is emitted.
  - The next operation, (1+1j)×(1−1j), yields re=2, im=0.
- Back-to-back: (2+0j)×(0+3j) with ctrl 01, then (−1−1j)×(−1+1j) with ctrl 10, `out_ready` always 1:
  - First result is re=0, im=6, ctrl 01.
  - Second result is re=2, im=0, ctrl 10.
  - The two results are 6 cycles apart.
